uart_port_ctrl: RTL

- Sequences the CPU's `uart` device onto an FT245-style parallel USB FIFO chip.
- Holds one RX byte and one TX byte, and drives the chip's read and write strobes with timed pulses.
- Exports the DI (byte available) and DO (can accept byte) status flags that CPU polling loops branch on.
- Sits between the CPU bus decode (`uart` as A-bus source and as target) and the external UART chip pins.

---
 rtl/uart_port_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_port_ctrl.sv
// Sequences the CPU uart device onto an FT245-style USB FIFO: one RX and one TX holding byte, timed strobes.
// Define UART_PORT_RR_ARB_EN for round-robin read/write arbitration; the default build is write-first.
module uart_port_ctrl #(
    parameter int RD_PULSE = 2,
    parameter int WR_PULSE = 2,
    parameter int RECOVERY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_rd,
    output logic [7:0] cpu_rdata,
    output logic       flag_di,
    output logic       flag_do,
    output logic       tx_overrun,
    input  logic       _rxf,
    input  logic       _txe,
    output logic       _rd,
    output logic       wr,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe
);

    localparam int MAX_AB  = (RD_PULSE > WR_PULSE) ? RD_PULSE : WR_PULSE;
    localparam int MAX_CNT = (MAX_AB > RECOVERY) ? MAX_AB : RECOVERY;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_PULSE - 1);
    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(RECOVERY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACTIVE,
        RD_RECOVER,
        WR_SETUP,
        WR_ACTIVE,
        WR_RECOVER
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rxf_meta_q, rxf_meta_d, rxf_s_q, rxf_s_d;
    logic             txe_meta_q, txe_meta_d, txe_s_q, txe_s_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tx_pending_q, tx_pending_d;
    logic [7:0]       tx_buf_q, tx_buf_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             overrun_q, overrun_d;
    logic             rd_n_q, rd_n_d;
    logic             wr_q, wr_d;
    logic             d_oe_q, d_oe_d;
    logic [7:0]       d_out_q, d_out_d;
`ifdef UART_PORT_RR_ARB_EN
    logic             last_was_write_q, last_was_write_d;
`endif

    logic want_w, want_r, start_w, start_r, rd_done, wr_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rxf_meta_q   <= 1'b1;
            rxf_s_q      <= 1'b1;
            txe_meta_q   <= 1'b1;
            txe_s_q      <= 1'b1;
            rx_valid_q   <= 1'b0;
            tx_pending_q <= 1'b0;
            tx_buf_q     <= '0;
            rdata_q      <= '0;
            overrun_q    <= 1'b0;
            rd_n_q       <= 1'b1;
            wr_q         <= 1'b0;
            d_oe_q       <= 1'b0;
            d_out_q      <= '0;
`ifdef UART_PORT_RR_ARB_EN
            last_was_write_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rxf_meta_q   <= rxf_meta_d;
            rxf_s_q      <= rxf_s_d;
            txe_meta_q   <= txe_meta_d;
            txe_s_q      <= txe_s_d;
            rx_valid_q   <= rx_valid_d;
            tx_pending_q <= tx_pending_d;
            tx_buf_q     <= tx_buf_d;
            rdata_q      <= rdata_d;
            overrun_q    <= overrun_d;
            rd_n_q       <= rd_n_d;
            wr_q         <= wr_d;
            d_oe_q       <= d_oe_d;
            d_out_q      <= d_out_d;
`ifdef UART_PORT_RR_ARB_EN
            last_was_write_q <= last_was_write_d;
`endif
        end
    end

    // Arbitration uses pre-edge rx_valid, so a same-cycle cpu_rd cannot launch a read.
    always_comb begin
        want_w = tx_pending_q & ~txe_s_q;
        want_r = ~rx_valid_q & ~rxf_s_q;
`ifdef UART_PORT_RR_ARB_EN
        start_w = (state_q == IDLE) & want_w & (~want_r | ~last_was_write_q);
`else
        start_w = (state_q == IDLE) & want_w;
`endif
        start_r = (state_q == IDLE) & want_r & ~start_w;
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_done = 1'b0;
        wr_done = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_w)      state_d = WR_SETUP;
                else if (start_r) state_d = RD_ACTIVE;
            end
            RD_ACTIVE: begin
                if (cnt_q == RD_LAST) begin
                    state_d = RD_RECOVER;
                    cnt_d   = '0;
                    rd_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_RECOVER, WR_RECOVER: begin
                if (cnt_q == REC_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR_SETUP: begin
                state_d = WR_ACTIVE;
                cnt_d   = '0;
            end
            WR_ACTIVE: begin
                if (cnt_q == WR_LAST) begin
                    state_d = WR_RECOVER;
                    cnt_d   = '0;
                    wr_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes decode from the next state so each pin is a clean flop output.
    always_comb begin
        rxf_meta_d = _rxf;
        rxf_s_d    = rxf_meta_q;
        txe_meta_d = _txe;
        txe_s_d    = txe_meta_q;
        rd_n_d     = (state_d != RD_ACTIVE);
        wr_d       = (state_d == WR_ACTIVE);
        d_oe_d     = (state_d == WR_SETUP) || (state_d == WR_ACTIVE) ||
                     ((state_d == WR_RECOVER) && (cnt_d == '0));
        d_out_d    = start_w ? tx_buf_q : d_out_q;
        rdata_d    = rd_done ? d_in : rdata_q;

        rx_valid_d = rx_valid_q;
        if (cpu_rd && rx_valid_q) rx_valid_d = 1'b0;
        if (rd_done)              rx_valid_d = 1'b1;

        tx_buf_d     = tx_buf_q;
        tx_pending_d = tx_pending_q;
        overrun_d    = overrun_q;
        if (cpu_wr) begin
            if (tx_pending_q) begin
                overrun_d = 1'b1;
            end else begin
                tx_buf_d     = cpu_wdata;
                tx_pending_d = 1'b1;
            end
        end
        if (wr_done) tx_pending_d = 1'b0;
`ifdef UART_PORT_RR_ARB_EN
        last_was_write_d = last_was_write_q;
        if (start_w)      last_was_write_d = 1'b1;
        else if (start_r) last_was_write_d = 1'b0;
`endif
    end

    assign cpu_rdata  = rdata_q;
    assign flag_di    = rx_valid_q;
    assign flag_do    = ~tx_pending_q;
    assign tx_overrun = overrun_q;
    assign _rd        = rd_n_q;
    assign wr         = wr_q;
    assign d_out      = d_out_q;
    assign d_oe       = d_oe_q;

endmodule
